// File: rtl/shared_memory_responder.sv
// Memory-side responder: arbitrates the fetch and data ports onto one word RAM,
// inserts LATENCY wait cycles per access and acknowledges with one-cycle valid pulses.
module shared_memory_responder #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ifReq,
    input  logic [31:0] ifAddress,
    output logic [31:0] ifData,
    output logic        ifValid,
    output logic        ifStall,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic [31:0] dAddress,
    input  logic [31:0] writeData,
    output logic [31:0] readData,
    output logic        dValid,
    output logic        dStall,
    output logic        misaligned
);

    localparam int         DEPTH      = 1 << ADDR_WIDTH;
    localparam logic [3:0] LOAD_COUNT = 4'(LATENCY - 1);

    generate
        if (LATENCY < 1 || LATENCY > 15) begin : gBadLatency
            $error("shared_memory_responder: LATENCY must be within 1..15");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        DONE = 2'b10
    } state_t;

    function automatic logic offWord(input logic [1:0] lowBits);
        return lowBits != 2'b00;
    endfunction

    state_t                  state_r;
    state_t                  nextState_s;
    logic [3:0]              count_r;
    logic                    selData_r;
    logic                    isStore_r;
    logic [ADDR_WIDTH-1:0]   index_r;
    logic [1:0]              lowBits_r;
    logic [31:0]             storeData_r;
    logic [31:0]             mem_r [0:DEPTH-1];

    logic [31:0]             ifData_r;
    logic [31:0]             readData_r;
    logic                    ifValid_r;
    logic                    dValid_r;
    logic                    misaligned_r;

    logic                    dataReq_s;
    logic                    anyReq_s;
    logic                    access_s;
    logic [ADDR_WIDTH-1:0]   reqIndex_s;
    logic [1:0]              reqLow_s;
    logic                    unusedAddrBits_s;

    // Upper address bits are deliberately dropped so accesses wrap modulo the RAM size.
    assign unusedAddrBits_s = ^{ifAddress[31:ADDR_WIDTH+2], dAddress[31:ADDR_WIDTH+2]};

    // Request decode and port mux; the data port wins when both ask.
    always_comb begin
        dataReq_s  = memRead | memWrite;
        anyReq_s   = dataReq_s | ifReq;
        access_s   = (state_r == WAIT) && (count_r == 4'd0);
        reqIndex_s = '0;
        reqLow_s   = 2'b00;
        if (dataReq_s) begin
            reqIndex_s = dAddress[ADDR_WIDTH+1:2];
            reqLow_s   = dAddress[1:0];
        end else begin
            reqIndex_s = ifAddress[ADDR_WIDTH+1:2];
            reqLow_s   = ifAddress[1:0];
        end
    end

    // Next-state logic.
    always_comb begin
        nextState_s = state_r;
        case (state_r)
            IDLE: begin
                if (anyReq_s) begin
                    nextState_s = WAIT;
                end else begin
                    nextState_s = IDLE;
                end
            end
            WAIT: begin
                if (count_r == 4'd0) begin
                    nextState_s = DONE;
                end else begin
                    nextState_s = WAIT;
                end
            end
            DONE:    nextState_s = IDLE;
            default: nextState_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= nextState_s;
        end
    end

    // Request latch at accept and wait-cycle countdown.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_r     <= 4'd0;
            selData_r   <= 1'b0;
            isStore_r   <= 1'b0;
            index_r     <= '0;
            lowBits_r   <= 2'b00;
            storeData_r <= 32'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (anyReq_s) begin
                        selData_r   <= dataReq_s;
                        isStore_r   <= memWrite;
                        index_r     <= reqIndex_s;
                        lowBits_r   <= reqLow_s;
                        storeData_r <= writeData;
                        count_r     <= LOAD_COUNT;
                    end
                end
                WAIT: begin
                    if (count_r != 4'd0) begin
                        count_r <= count_r - 4'd1;
                    end
                end
                default: count_r <= count_r;
            endcase
        end
    end

    // Response registers: data is captured on the access edge, valids last one cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ifData_r     <= 32'd0;
            readData_r   <= 32'd0;
            ifValid_r    <= 1'b0;
            dValid_r     <= 1'b0;
            misaligned_r <= 1'b0;
        end else begin
            ifValid_r    <= access_s & ~selData_r;
            dValid_r     <= access_s & selData_r;
            misaligned_r <= access_s & offWord(lowBits_r);
            if (access_s) begin
                // Stores also return the pre-write word (read-first RAM).
                if (selData_r) begin
                    readData_r <= mem_r[index_r];
                end else begin
                    ifData_r <= mem_r[index_r];
                end
            end
        end
    end

    // RAM write port; never cleared by reset, and an abandoned store never reaches here.
    always_ff @(posedge clock) begin
        if (access_s && selData_r && isStore_r) begin
            mem_r[index_r] <= storeData_r;
        end
    end

    assign ifData     = ifData_r;
    assign readData   = readData_r;
    assign ifValid    = ifValid_r;
    assign dValid     = dValid_r;
    assign misaligned = misaligned_r;
    assign ifStall    = ifReq & ~ifValid_r;
    assign dStall     = (memRead | memWrite) & ~dValid_r;

endmodule

// File: tb/tb_shared_memory_responder.sv
// Self-checking bench: directed tables, hand-written corner sequences and a
// randomized run against a word-array reference model.
module tb_shared_memory_responder;

    localparam int AW        = 10;
    localparam int LAT_A     = 2;
    localparam int WORDS     = 1 << AW;
    localparam int P_FETCH   = 0;
    localparam int P_LOAD    = 1;
    localparam int P_STORE   = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b1;

    logic        ifReq = 1'b0, memRead = 1'b0, memWrite = 1'b0;
    logic [31:0] ifAddress = 32'd0, dAddress = 32'd0, writeData = 32'd0;
    logic [31:0] ifData, readData;
    logic        ifValid, ifStall, dValid, dStall, misaligned;

    logic        ifReqB = 1'b0, memReadB = 1'b0, memWriteB = 1'b0;
    logic [31:0] ifAddressB = 32'd0, dAddressB = 32'd0, writeDataB = 32'd0;
    logic [31:0] ifDataB, readDataB;
    logic        ifValidB, ifStallB, dValidB, dStallB, misalignedB;

    int errors = 0;
    int checks = 0;
    logic [31:0] model [int];

    always #5 clock = ~clock;

    shared_memory_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT_A)) dutA (
        .clock(clock), .reset(reset),
        .ifReq(ifReq), .ifAddress(ifAddress), .ifData(ifData), .ifValid(ifValid), .ifStall(ifStall),
        .memRead(memRead), .memWrite(memWrite), .dAddress(dAddress), .writeData(writeData),
        .readData(readData), .dValid(dValid), .dStall(dStall), .misaligned(misaligned)
    );

    shared_memory_responder #(.ADDR_WIDTH(AW), .LATENCY(1)) dutB (
        .clock(clock), .reset(reset),
        .ifReq(ifReqB), .ifAddress(ifAddressB), .ifData(ifDataB), .ifValid(ifValidB), .ifStall(ifStallB),
        .memRead(memReadB), .memWrite(memWriteB), .dAddress(dAddressB), .writeData(writeDataB),
        .readData(readDataB), .dValid(dValidB), .dStall(dStallB), .misaligned(misalignedB)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int wordOf(input logic [31:0] addr);
        return int'((addr >> 2) % WORDS);
    endfunction

    // One access on dutA; entered just after a rising edge in an idle cycle,
    // returns just after the edge following the valid cycle with requests dropped.
    task automatic access(input int port, input logic [31:0] addr, input logic [31:0] wd,
                          output logic [31:0] data, output logic mis);
        int   cyc = 0;
        logic got = 1'b0;
        data = 32'd0;
        mis  = 1'b0;
        ifReq    = (port == P_FETCH);
        memRead  = (port == P_LOAD);
        memWrite = (port == P_STORE);
        if (port == P_FETCH) ifAddress = addr; else dAddress = addr;
        writeData = wd;
        while (!got && cyc < 40) begin
            @(negedge clock);
            if ((port == P_FETCH) ? ifValid : dValid) begin
                got  = 1'b1;
                data = (port == P_FETCH) ? ifData : readData;
                mis  = misaligned;
                chk("latency", cyc, LAT_A + 1);
                chk("stall_at_valid", (port == P_FETCH) ? ifStall : dStall, 1'b0);
                chk("other_valid", (port == P_FETCH) ? dValid : ifValid, 1'b0);
            end else begin
                if ((port == P_FETCH ? ifStall : dStall) !== 1'b1)
                    chk("stall_pending", (port == P_FETCH) ? ifStall : dStall, 1'b1);
                @(posedge clock); #1;
                cyc++;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL timeout: no valid for port %0d after %0d cycles", port, cyc);
        end
        @(posedge clock); #1;
        ifReq = 1'b0; memRead = 1'b0; memWrite = 1'b0;
        chk("valid_one_cycle", {30'd0, ifValid, dValid}, 32'd0);
        chk("misaligned_cleared", misaligned, 1'b0);
    endtask

    // Access checked against the reference model (data when known, misaligned always).
    task automatic doOp(input int port, input logic [31:0] addr, input logic [31:0] wd);
        logic [31:0] data;
        logic        mis;
        int          w;
        w = wordOf(addr);
        access(port, addr, wd, data, mis);
        if (model.exists(w)) chk("model_data", data, model[w]);
        chk("model_misaligned", mis, (addr % 4) != 0);
        if (port == P_STORE) model[w] = wd;
    endtask

    typedef struct {
        int          port;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] expData;
        logic        expMis;
    } vec_t;

    vec_t vecs [7];

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        logic [31:0] data;
        logic        mis;
        int          cyc;

        // Reset state.
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_ifData", ifData, 32'd0);
        chk("rst_readData", readData, 32'd0);
        chk("rst_valids", {29'd0, ifValid, dValid, misaligned}, 32'd0);
        chk("rst_stalls", {30'd0, ifStall, dStall}, 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;

        // Preload through the store port.
        doOp(P_STORE, 32'h0000_0014, 32'hDEAD_BEEF);
        doOp(P_STORE, 32'h0000_0020, 32'hCAFE_F00D);
        doOp(P_STORE, 32'h0000_0000, 32'h0000_0A0A);
        doOp(P_STORE, 32'h0000_0040, 32'h0BAD_F00D);

        // Basic fetch of word 5.
        access(P_FETCH, 32'h0000_0014, 32'd0, data, mis);
        chk("fetch_data", data, 32'hDEAD_BEEF);
        chk("fetch_mis", mis, 1'b0);

        // Store returns old word, load sees the new one.
        access(P_STORE, 32'h0000_0020, 32'h1234_5678, data, mis);
        chk("store_old", data, 32'hCAFE_F00D);
        model[8] = 32'h1234_5678;
        access(P_LOAD, 32'h0000_0020, 32'd0, data, mis);
        chk("raw_load", data, 32'h1234_5678);

        // Directed vector table: wrap, misalignment, store-then-fetch.
        vecs[0] = '{P_LOAD,  32'h0000_1002, 32'd0,         32'h0000_0A0A, 1'b1};
        vecs[1] = '{P_FETCH, 32'h0000_0015, 32'd0,         32'hDEAD_BEEF, 1'b1};
        vecs[2] = '{P_STORE, 32'h0000_1014, 32'h1111_2222, 32'hDEAD_BEEF, 1'b0};
        vecs[3] = '{P_FETCH, 32'h0000_0014, 32'd0,         32'h1111_2222, 1'b0};
        vecs[4] = '{P_LOAD,  32'hFFFF_F003, 32'd0,         32'h0000_0A0A, 1'b1};
        vecs[5] = '{P_STORE, 32'h0000_0022, 32'h9999_AAAA, 32'h1234_5678, 1'b1};
        vecs[6] = '{P_LOAD,  32'h0000_0020, 32'd0,         32'h9999_AAAA, 1'b0};
        for (int i = 0; i < 7; i++) begin
            access(vecs[i].port, vecs[i].addr, vecs[i].wd, data, mis);
            chk($sformatf("vec%0d_data", i), data, vecs[i].expData);
            chk($sformatf("vec%0d_mis", i), mis, vecs[i].expMis);
            if (vecs[i].port == P_STORE) model[wordOf(vecs[i].addr)] = vecs[i].wd;
        end

        // Simultaneous fetch and load: data first, fetch accepted after data DONE.
        ifReq = 1'b1; ifAddress = 32'h0000_0014;
        memRead = 1'b1; dAddress = 32'h0000_0020;
        for (int c = 0; c <= 8; c++) begin
            @(negedge clock);
            chk($sformatf("conc_dValid_c%0d", c), dValid, c == 3);
            chk($sformatf("conc_ifValid_c%0d", c), ifValid, c == 7);
            chk($sformatf("conc_ifStall_c%0d", c), ifStall, c <= 6);
            chk($sformatf("conc_dStall_c%0d", c), dStall, c <= 2);
            if (c == 3) chk("conc_readData", readData, 32'h9999_AAAA);
            if (c == 7) chk("conc_ifData", ifData, 32'h1111_2222);
            @(posedge clock); #1;
            if (c == 3) memRead = 1'b0;
            if (c == 7) ifReq = 1'b0;
        end

        // Store abandoned by reset in its first wait cycle.
        memWrite = 1'b1; dAddress = 32'h0000_0040; writeData = 32'hAAAA_5555;
        @(posedge clock); #1;
        reset = 1'b1;
        #1;
        chk("abort_readData", readData, 32'd0);
        chk("abort_ifData", ifData, 32'd0);
        chk("abort_flags", {29'd0, ifValid, dValid, misaligned}, 32'd0);
        memWrite = 1'b0;
        @(posedge clock);
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;
        access(P_LOAD, 32'h0000_0040, 32'd0, data, mis);
        chk("abort_preserved", data, 32'h0BAD_F00D);

        // Randomized run over a fully initialised window of 32 words.
        for (int i = 0; i < 32; i++) doOp(P_STORE, i * 4, $urandom);
        for (int n = 0; n < 80; n++) begin
            logic [31:0] a;
            a = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(0, 3));
            doOp($urandom_range(0, 2), a, $urandom);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clock); #1;
            end
        end

        // LATENCY=1 instance: store, then a continuously held load.
        memWriteB = 1'b1; dAddressB = 32'h0000_0008; writeDataB = 32'h55AA_33CC;
        cyc = 0;
        @(negedge clock);
        while (!dValidB && cyc < 20) begin
            @(posedge clock); #1;
            cyc++;
            @(negedge clock);
        end
        chk("b_store_latency", cyc, 2);
        @(posedge clock); #1;
        memWriteB = 1'b0;
        @(posedge clock); #1;
        memReadB = 1'b1;
        for (int c = 0; c <= 11; c++) begin
            @(negedge clock);
            chk($sformatf("b_dValid_c%0d", c), dValidB, (c <= 8) && (c % 3 == 2));
            chk($sformatf("b_dStall_c%0d", c), dStallB, (c <= 8) && (c % 3 != 2));
            if (dValidB) chk($sformatf("b_data_c%0d", c), readDataB, 32'h55AA_33CC);
            @(posedge clock); #1;
            if (c == 8) memReadB = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
